// File: rtl/wb_stage_pkg.sv
// Shared RV32I definitions used by the write-back stage and its load formatter.
package wb_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Aligns a raw word-aligned read and sign/zero-extends it according to the
// load funct3. Unknown funct3 encodings produce zero and raise illegal_o.
module wb_stage_load_formatter
    import wb_stage_pkg::*;
(
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] raw_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select then extension; addr_lo_i[0] is deliberately ignored for halfwords.
    always_comb begin
        byte_v    = raw_i[{addr_lo_i, 3'b000} +: 8];
        half_v    = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        data_o    = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            LB:      data_o = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            LH:      data_o = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, half_v};
            LW:      data_o = raw_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: retires ALU results directly, waits for the
// data-memory response on loads, and drives the register-file write port.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_reg_write,
    input  logic                      in_is_load,
    input  logic [2:0]                in_load_funct3,
    input  logic [1:0]                in_addr_lo,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [DATA_WIDTH-1:0]     rf_rd_data,
    output logic                      pending_valid,
    output logic [REG_ADDR_WIDTH-1:0] pending_rd,
    output logic                      wb_err
);

    wb_state_e                 state_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [2:0]                funct3_q;
    logic [1:0]                addr_lo_q;
    logic                      reg_write_q;
    logic                      rf_write_en_q;
    logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_q;
    logic [DATA_WIDTH-1:0]     rf_rd_data_q;
    logic                      wb_err_q;
    logic [DATA_WIDTH-1:0]     fmt_data;
    logic                      fmt_illegal;

    wb_stage_load_formatter u_fmt (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .raw_i     (dmem_rdata),
        .data_o    (fmt_data),
        .illegal_o (fmt_illegal)
    );

    // Handshake FSM with registered write port; write enable is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_q          <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            reg_write_q   <= 1'b0;
            rf_write_en_q <= 1'b0;
            rf_rd_addr_q  <= '0;
            rf_rd_data_q  <= '0;
            wb_err_q      <= 1'b0;
        end else begin
            rf_write_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A response with no load outstanding is a protocol error.
                    if (dmem_rvalid) begin
                        wb_err_q <= 1'b1;
                    end
                    if (in_valid) begin
                        if (in_is_load) begin
                            rd_q        <= in_rd_addr;
                            funct3_q    <= in_load_funct3;
                            addr_lo_q   <= in_addr_lo;
                            reg_write_q <= in_reg_write;
                            state_q     <= WAIT_LOAD;
                        end else if (in_reg_write && (in_rd_addr != '0)) begin
                            rf_write_en_q <= 1'b1;
                            rf_rd_addr_q  <= in_rd_addr;
                            rf_rd_data_q  <= in_result;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        if (fmt_illegal) begin
                            wb_err_q <= 1'b1;
                        end
                        if (reg_write_q && (rd_q != '0)) begin
                            rf_write_en_q <= 1'b1;
                            rf_rd_addr_q  <= rd_q;
                            rf_rd_data_q  <= fmt_data;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign pending_valid = (state_q == WAIT_LOAD);
    assign pending_rd    = pending_valid ? rd_q : '0;
    assign rf_write_en   = rf_write_en_q;
    assign rf_rd_addr    = rf_rd_addr_q;
    assign rf_rd_data    = rf_rd_data_q;
    assign wb_err        = wb_err_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RV32I core. Sits directly upstream of the register file and drives its write port (rd_addr, rd_data, write_en).
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- ALU results are written back directly. For loads, the stage waits for the data-memory response, then aligns and sign- or zero-extends it before writing.
- Exports the pending-load destination so decode can stall on load-use hazards.

Parameters:
- DATA_WIDTH, 32, datapath width (from _riscv_defines).
- REG_ADDR_WIDTH, 5, register index width (from _riscv_defines).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  memory stage presents a retiring instruction.
- in_ready  out  1  stage can accept; equals (state == IDLE).
- in_rd_addr  in  REG_ADDR_WIDTH  destination register.
- in_result  in  DATA_WIDTH  ALU/jump result for non-loads.
- in_reg_write  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load.
- in_load_funct3  in  3  load funct3 (LB/LH/LW/LBU/LHU).
- in_addr_lo  in  2  low two bits of the load byte address.
- dmem_rvalid  in  1  data-memory read response valid, single-cycle pulse.
- dmem_rdata  in  DATA_WIDTH  raw word-aligned read data.
- rf_write_en  out  1  register-file write enable.
- rf_rd_addr  out  REG_ADDR_WIDTH  register-file write address.
- rf_rd_data  out  DATA_WIDTH  register-file write data.
- pending_valid  out  1  a load is outstanding.
- pending_rd  out  REG_ADDR_WIDTH  rd of the outstanding load (0 when none).
- wb_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low at posedge):
  - state = IDLE.
  - rf_write_en = 0, rf_rd_addr = 0, rf_rd_data = 0.
  - pending_valid = 0, pending_rd = 0, wb_err = 0.
  - Reset overrides all other inputs in that cycle.
- Handshake:
  - Transfer occurs on a posedge where in_valid && in_ready.
  - in_ready is purely a function of state.
- States:
  - IDLE:
    - Non-load transfer: register write next cycle and stay in IDLE.
    - Load transfer: latch rd, funct3, addr_lo and reg_write, then go to WAIT_LOAD.
  - WAIT_LOAD: in_ready = 0, pending_valid = 1. On dmem_rvalid, register the formatted write for the next cycle and return to IDLE.
- Write rules:
  - rf_* outputs are registered. rf_write_en is high for exactly one cycle.
  - Non-load latency: write 1 cycle after transfer.
  - Load latency: write 1 cycle after dmem_rvalid.
  - rf_write_en = reg_write && rd != 0. rd = 0 never asserts a write, but a load to x0 still waits for its response.
  - When no write occurs, rf_rd_addr/rf_rd_data hold their previous values.
- Load formatting (funct3, byte lane = addr_lo):
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: halfword[addr_lo[1]], sign-extended.
  - 101 LHU: halfword[addr_lo[1]], zero-extended.
  - 010 LW: full word; addr_lo ignored.
  - 011/110/111: data = 0 and wb_err set. The write still proceeds if enabled.
  - addr_lo[0] is ignored for halfwords; alignment is checked upstream.
- dmem_rvalid while in IDLE: ignored for writes; sets wb_err.
- Non-load transfer and a stale dmem_rvalid in the same IDLE cycle: the non-load write proceeds normally and wb_err is set.
- Same-cycle write and read hazards are handled by the register file's forwarding; this stage adds no bypass.
- Reset during WAIT_LOAD: the pending load is discarded. A response arriving later (in IDLE) sets wb_err and produces no write.
- wb_err is cleared only by reset.

Decomposition:
- Shared package _riscv_defines gets:
  - load_funct3_e enum (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101).
  - wb_state_e enum (IDLE, WAIT_LOAD).
- Sub-module load_formatter: combinational; inputs funct3, addr_lo, raw word; outputs formatted data and an illegal flag. Instantiated once in wb_stage.

Test Plan:
- ALU write: transfer rd=5, result=0xDEADBEEF, reg_write=1 → next cycle rf_write_en=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF; in_ready stays 1.
- Signed byte load: LB, addr_lo=2, rd=7; dmem_rvalid after 3 cycles with rdata=0x12F45678 → in_ready=0 and pending_valid=1/pending_rd=7 during the wait; one cycle after rvalid, write rd=7 with 0xFFFFFFF4.
- Halfword loads with rdata=0x8001ABCD, addr_lo=2 → LHU writes 0x00008001; LH writes 0xFFFF8001.
- x0 destination: non-load rd=0 → no rf_write_en. LW rd=0 → waits for rvalid, no write, then in_ready returns to 1.
- Errors: funct3=3'b011 load with response → write data 0 and wb_err=1. In a fresh run, rvalid while IDLE → wb_err=1 and no write.
- Reset mid-load: LW rd=9, assert rst_n=0 in WAIT_LOAD, then rvalid after release → no write, pending_valid=0, wb_err=1.
